// File: rtl/bw_mult_pkg.sv
// bw_mult_pkg: shared defaults and tag-width helper for the shared multiplier scheduler
package bw_mult_pkg;
  localparam int N_DEF = 16;
  localparam int NREQ_DEF = 4;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bw_mult.sv
// bw_mult: combinational Baugh-Wooley signed N x N multiplier with 2N-bit product
module bw_mult #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  logic [N-1:0][N-1:0] row;
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i == N-1) begin : g_neg
      assign row[i] = {a[N-1] & b[i], ~(a[N-2:0] & {(N-1){b[i]}})};
    end else begin : g_pos
      assign row[i] = {~(a[N-1] & b[i]), a[N-2:0] & {(N-1){b[i]}}};
    end
  end
  always_comb begin
    p = '0;
    p[2*N-1] = 1'b1;
    p[N] = 1'b1;
    for (int i = 0; i < N; i++) p = p + ((2*N)'(row[i]) << i);
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at ptr with explicit modulo wrap
module rr_arbiter
  import bw_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic [IDW-1:0]  next_ptr
);
  logic found;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'((v >= NREQ) ? v - NREQ : v);
  endfunction
  always_comb begin
    found = 1'b0;
    gnt_idx = ptr;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        gnt_idx = wrap(int'(ptr) + k);
      end
    end
    gnt = (en && found) ? (NREQ'(1) << gnt_idx) : '0;
    next_ptr = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/bw_mult_sched.sv
// bw_mult_sched: round-robin sharing of one registered-in/registered-out signed multiplier
module bw_mult_sched
  import bw_mult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_p
);
  logic           s1_valid, s1_adv, s2_adv, accept;
  logic [N-1:0]   op_a, op_b;
  logic [IDW-1:0] op_id, ptr, gnt_idx, next_ptr;
  logic [2*N-1:0] prod;
  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = |req_ready;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (s1_adv && !rst),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .next_ptr(next_ptr)
  );
  bw_mult #(.N(N)) u_mult (
    .a(op_a),
    .b(op_b),
    .p(prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      if (s1_adv) s1_valid <= accept;
      if (accept) begin
        op_a  <= req_a[gnt_idx*N +: N];
        op_b  <= req_b[gnt_idx*N +: N];
        op_id <= gnt_idx;
        ptr   <= next_ptr;
      end
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        rsp_p     <= prod;
        rsp_id    <= op_id;
      end
    end
  end
endmodule

// File: tb/tb_bw_mult_sched.sv
// tb_bw_mult_sched: randomized scoreboard plus directed corner checks for bw_mult_sched
module tb_bw_mult_sched;
  localparam int N = 16;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_p;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  typedef struct {
    int             id;
    logic [2*N-1:0] p;
    int             e;
  } item_t;
  item_t q[$];
  int mptr = 0;
  int ecount = 0;
  logic [NREQ-1:0]   acc, s_rr;
  logic [NREQ-1:0]   pend = '0;
  logic [NREQ*N-1:0] pa, pb;
  logic              s_rv;
  logic [2*N-1:0]    s_rp, bp_p;
  logic [IDW-1:0]    s_id;
  int cnt [NREQ];
  logic [NREQ-1:0] seq [4];
  bw_mult_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_p    (rsp_p)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [2*N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] sa, sb;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    return sa * sb;
  endfunction
  function automatic logic [N-1:0] rnd_op();
    int s = $urandom_range(5);
    return s == 0 ? 16'h8000 : s == 1 ? 16'h7FFF : s == 2 ? 16'hFFFF : s == 3 ? '0 : N'($urandom);
  endfunction
  always @(negedge clk) begin : cmp
    int g;
    bit found, erv;
    logic [NREQ-1:0] er;
    item_t it;
    if (chk_on) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < NREQ && !found; k++) begin
        if (req_valid[(mptr + k) % NREQ]) begin
          found = 1'b1;
          g = (mptr + k) % NREQ;
        end
      end
      er = (!rst && found && (q.size() < 2 || rsp_ready)) ? NREQ'(1) << g : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      erv = q.size() > 0 && q[0].e != ecount;
      chk("rsp_valid", 64'(rsp_valid), 64'(erv));
      if (erv) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          checks++;
          assert (req_valid[i] && req_a[i*N +: N] == pa[i*N +: N] && req_b[i*N +: N] == pb[i*N +: N])
          else begin
            errors++;
            $display("FAIL hold_req%0d actual_valid=%0b required_valid=1", i, req_valid[i]);
          end
        end
      end
      pend = req_valid & ~req_ready;
      pa = req_a;
      pb = req_b;
      if (rst) begin
        q.delete();
        mptr = 0;
      end else begin
        if (erv && rsp_ready) void'(q.pop_front());
        if (er != '0) begin
          it.id = g;
          it.p = mul(req_a[g*N +: N], req_b[g*N +: N]);
          it.e = ecount + 1;
          q.push_back(it);
          mptr = (g + 1) % NREQ;
        end
      end
      ecount++;
    end
  end
  task automatic cyc(input logic [NREQ-1:0] want, input int pv, input int pr);
    @(negedge clk);
    s_rr = req_ready;
    s_rv = rsp_valid;
    s_rp = rsp_p;
    s_id = rsp_id;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] || !req_valid[i]) begin
        req_valid[i] = want[i] && ($urandom_range(99) < pv);
        if (req_valid[i]) begin
          req_a[i*N +: N] = rnd_op();
          req_b[i*N +: N] = rnd_op();
        end
      end
    end
    rsp_ready = $urandom_range(99) < pr;
  endtask
  task automatic one(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp);
    req_valid[i] = 1'b1;
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    cyc('0, 0, 100);
    chk("single_grant", 64'(s_rr), 64'(NREQ'(1) << i));
    cyc('0, 0, 100);
    chk("single_lat0", 64'(s_rv), 64'd0);
    cyc('0, 0, 100);
    chk("single_lat1", 64'(s_rv), 64'd1);
    chk("single_id", 64'(s_id), 64'(i));
    chk("single_p", 64'(s_rp), 64'(exp));
  endtask
  initial begin
    int n, mx, mn;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    cyc('0, 0, 100);
    chk("rst_valid", 64'(s_rv), 64'd0);
    chk("rst_p", 64'(s_rp), 64'd0);
    chk("rst_id", 64'(s_id), 64'd0);
    rst = 1'b0;
    one(2, 16'h7FFF, 16'h8000, 32'hC0008000);
    one(1, 16'h8000, 16'h8000, 32'h40000000);
    one(1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    one(1, 16'h0000, 16'h1234, 32'h00000000);
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    cyc('1, 100, 100);
    for (int c = 0; c < 100; c++) begin
      cyc('1, 100, 100);
      if (c < 4) seq[c] = s_rr;
      if (s_rv) cnt[s_id]++;
    end
    chk("fair_g0", 64'(seq[0]), 64'h4);
    chk("fair_g1", 64'(seq[1]), 64'h8);
    chk("fair_g2", 64'(seq[2]), 64'h1);
    chk("fair_g3", 64'(seq[3]), 64'h2);
    mx = cnt[0];
    mn = cnt[0];
    for (int i = 1; i < NREQ; i++) begin
      mx = cnt[i] > mx ? cnt[i] : mx;
      mn = cnt[i] < mn ? cnt[i] : mn;
    end
    chk("fair_spread", 64'(mx - mn <= 1), 64'd1);
    repeat (8) cyc('0, 0, 100);
    req_valid[0] = 1'b1;
    req_a[N-1:0] = rnd_op();
    req_b[N-1:0] = rnd_op();
    rsp_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc(4'b0001, 100, 0);
      chk("bp_ready", 64'(s_rr[0]), 64'(k <= 2));
      if (k == 3) bp_p = s_rp;
      if (k > 3) chk("bp_hold", 64'(s_rp), 64'(bp_p));
    end
    rsp_ready = 1'b1;
    n = 0;
    repeat (6) begin
      cyc('0, 0, 100);
      if (s_rv) n++;
    end
    chk("bp_count", 64'(n), 64'd3);
    rsp_ready = 1'b0;
    repeat (3) cyc('1, 100, 0);
    rst = 1'b1;
    cyc('1, 100, 0);
    chk("rst_mid_ready", 64'(s_rr), 64'd0);
    chk("rst_mid_full", 64'(s_rv), 64'd1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cyc('1, 100, 100);
    chk("rst_mid_valid", 64'(s_rv), 64'd0);
    chk("rst_mid_ptr", 64'(s_rr), 64'h1);
    repeat (10000) cyc('1, 50, 70);
    repeat (10) cyc('0, 0, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
